// File: rtl/ram_wb_slave.sv
`default_nettype none
// ============================================================================
// Module   : ram_wb_slave
// Purpose  : Wishbone-classic slave in front of a single-port byte-write RAM
//            with one-cycle registered read latency. Optional address error
//            reporting is enabled with the RAM_WB_ERR_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module ram_wb_slave #(
    parameter  int RAM_DEPTH = 1024,
    parameter  int DW        = 32,
    localparam int AW        = $clog2(RAM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,

    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [31:0]   wb_adr_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,

    output logic          ram_we_o,
    output logic [AW-1:0] ram_adr_o,
    output logic [3:0]    ram_be_o,
    output logic [DW-1:0] ram_dat_o,
    input  logic [DW-1:0] ram_dat_i
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RD_WAIT = 2'd1;
    localparam logic [1:0] c_ACK     = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [DW-1:0] r_rdata;
    logic          w_req;
    logic          w_adr_err;
    logic          w_err_flag;
    logic          w_ram_we;
    logic          w_rd_load;
    logic          w_ack;
    logic          w_err;

    assign w_req = wb_cyc_i & wb_stb_i;

`ifdef RAM_WB_ERR_EN
    logic r_err_flag;

    // Misaligned or out-of-range byte addresses are rejected instead of aliased.
    assign w_adr_err  = (|wb_adr_i[31:AW+2]) | (|wb_adr_i[1:0]);
    assign w_err_flag = r_err_flag;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err_flag <= 1'b0;
        end else if (r_state == c_IDLE) begin
            r_err_flag <= w_req & w_adr_err;
        end
    end
`else
    logic w_unused_adr;

    assign w_adr_err    = 1'b0;
    assign w_err_flag   = 1'b0;
    assign w_unused_adr = &{1'b0, wb_adr_i[31:AW+2], wb_adr_i[1:0]};
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_req) begin
                    w_next_state = (wb_we_i | w_adr_err) ? c_ACK : c_RD_WAIT;
                end
            end
            c_RD_WAIT: w_next_state = wb_cyc_i ? c_ACK : c_IDLE;
            c_ACK:     w_next_state = c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_ram_we  = 1'b0;
        w_rd_load = 1'b0;
        w_ack     = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            c_IDLE:    w_ram_we  = w_req & wb_we_i & ~w_adr_err;
            c_RD_WAIT: w_rd_load = wb_cyc_i;
            c_ACK: begin
                w_ack = ~w_err_flag;
                w_err = w_err_flag;
            end
            default: begin
                w_ram_we  = 1'b0;
                w_rd_load = 1'b0;
            end
        endcase
    end

    // Read data is captured only on a completed read so aborts leave it intact.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rdata <= '0;
        end else if (w_rd_load) begin
            r_rdata <= ram_dat_i;
        end
    end

    assign wb_dat_o  = r_rdata;
    assign wb_ack_o  = w_ack;
    assign wb_err_o  = w_err;

    assign ram_we_o  = w_ram_we & rst_n_i;
    assign ram_adr_o = wb_adr_i[AW+1:2];
    assign ram_be_o  = wb_sel_i;
    assign ram_dat_o = wb_dat_i;

endmodule
`default_nettype wire

// File: tb/tb_ram_wb_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_wb_slave
// Purpose  : Self-checking bench for ram_wb_slave with a behavioural RAM and a
//            word-array reference model. Honours RAM_WB_ERR_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_wb_slave;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int NPRE  = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          we = 1'b0;
    logic [31:0]   adr = '0;
    logic [3:0]    sel = '0;
    logic [31:0]   wdat = '0;
    logic [31:0]   dat_o;
    logic          ack;
    logic          err;
    logic          ram_we;
    logic [AW-1:0] ram_adr;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdat;
    logic [31:0]   ram_rdat;

    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_idx = '0;
    logic [31:0]   pl_dat = '0;
    logic [31:0]   ram [0:DEPTH-1];

    logic [31:0]   ref_mem [0:DEPTH-1];
    logic [31:0]   exp_dat;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    ram_wb_slave #(.RAM_DEPTH(DEPTH), .DW(32)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_sel_i  (sel),
        .wb_dat_i  (wdat),
        .wb_dat_o  (dat_o),
        .wb_ack_o  (ack),
        .wb_err_o  (err),
        .ram_we_o  (ram_we),
        .ram_adr_o (ram_adr),
        .ram_be_o  (ram_be),
        .ram_dat_o (ram_wdat),
        .ram_dat_i (ram_rdat)
    );

    // Behavioural block RAM: byte-lane writes, one-cycle registered read.
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_idx] <= pl_dat;
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) ram[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
            end
        end
        ram_rdat <= ram[ram_adr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic addr_is_err(input logic [31:0] a);
`ifdef RAM_WB_ERR_EN
        return (a >= 32'(4 * DEPTH)) || ((a % 4) != 0);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // One complete Wishbone transfer, checked against the reference model.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
        int   idx;
        int   n;
        int   exp_lat;
        logic e;
        logic done;
        idx     = int'((a >> 2) % DEPTH);
        e       = addr_is_err(a);
        exp_lat = (e || w) ? 1 : 2;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        #1;
        chk("pass_adr", 32'(ram_adr), 32'(idx));
        chk("pass_be",  32'(ram_be), 32'(s));
        chk("pass_dat", ram_wdat, d);
        chk("ram_we_idle", 32'(ram_we), 32'(w && !e));
        n = 0;
        done = 1'b0;
        while (!done && n < 6) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk("ram_we_busy", 32'(ram_we), 32'd0);
            if (ack || err) done = 1'b1;
        end
        chk("xfer_done", 32'(done), 32'd1);
        chk("latency", 32'(n), 32'(exp_lat));
        chk("ack", 32'(ack), 32'(!e));
        chk("err", 32'(err), 32'(e));
        if (!w && !e) exp_dat = ref_mem[idx];
        chk(w ? "dat_hold_wr" : "rdata", dat_o, exp_dat);
        if (w && !e) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("no_double", {30'd0, ack, err}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] hi;
        logic [31:0] lo;
        int          k;

        // Preload the first words of the RAM and mirror them in the model.
        pl_en = 1'b1;
        for (int i = 0; i < NPRE; i++) begin
            @(negedge clk);
            pl_idx     = AW'(i);
            pl_dat     = 32'h1000_0001 + 32'(i) * 32'h0103_0507;
            ref_mem[i] = pl_dat;
        end
        @(negedge clk);
        pl_en = 1'b0;

        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
        #1;
        chk("rst_ack",    32'(ack), 32'd0);
        chk("rst_err",    32'(err), 32'd0);
        chk("rst_dat",    dat_o, 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        exp_dat = '0;
        @(negedge clk);
        rst_n = 1'b1;

        xfer(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h10, 4'hF, 32'h0);
        chk("plan_word", dat_o, 32'hDEAD_BEEF);
        xfer(1'b1, 32'h10, 4'h4, 32'h00AA_0000);
        xfer(1'b0, 32'h10, 4'hF, 32'h0);
        chk("plan_lane", dat_o, 32'hDEAA_BEEF);
        xfer(1'b1, 32'h10, 4'h0, 32'h1234_5678);
        xfer(1'b0, 32'h10, 4'hF, 32'h0);
        chk("sel_zero", dat_o, 32'hDEAA_BEEF);

        // Back-to-back reads with the strobe held: one ack every third cycle.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0;
        k = 0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            chk("b2b_ack", 32'(ack), 32'(i % 3 == 2));
            if (i % 3 == 2) begin
                exp_dat = ref_mem[k];
                chk("b2b_dat", dat_o, exp_dat);
                k++;
                adr = 32'(k * 4);
            end
        end
        cyc = 1'b0; stb = 1'b0;

        // Abort: cycle dropped while the read is outstanding.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h14;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_quiet", {30'd0, ack, err}, 32'd0);
            chk("abort_dat", dat_o, exp_dat);
        end
        xfer(1'b0, 32'h18, 4'hF, 32'h0);

        // Reset asserted while the read is outstanding.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1C;
        @(posedge clk); #1;
        rst_n = 1'b0;
        we = 1'b1;
        #1;
        chk("rrst_ack",    32'(ack), 32'd0);
        chk("rrst_err",    32'(err), 32'd0);
        chk("rrst_dat",    dat_o, 32'd0);
        chk("rrst_ram_we", 32'(ram_we), 32'd0);
        exp_dat = '0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 32'h1C, 4'hF, 32'h0);

`ifdef RAM_WB_ERR_EN
        xfer(1'b1, 32'(4 * DEPTH), 4'hF, 32'h1234_5678);
        xfer(1'b0, 32'h0, 4'hF, 32'h0);
        chk("err_untouched", dat_o, 32'h1000_0001);
        xfer(1'b0, 32'h2, 4'hF, 32'h0);
`else
        xfer(1'b1, 32'(4 * DEPTH), 4'hF, 32'h1234_5678);
        xfer(1'b0, 32'h0, 4'hF, 32'h0);
        chk("alias_word0", dat_o, 32'h1234_5678);
`endif

        // Randomised mix of reads and writes with aliased/misaligned addresses.
        for (int t = 0; t < 40; t++) begin
            hi = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h000F_FFFF) : 32'd0;
            lo = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
            a  = (hi << (AW + 2)) | (32'($urandom_range(0, NPRE - 1)) << 2) | lo;
            xfer(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_wb_slave.md
# ram_wb_slave

Wishbone-classic slave that fronts the single-port, byte-write block RAM. It converts bus cycles (cyc/stb/we/sel) into RAM port accesses and absorbs the RAM's one-cycle registered read latency. It returns a one-cycle `ack_o` per transaction. It sits between the system bus interconnect and one RAM instance, driving the RAM's `we_i`, `adr_i`, `be_i` and `dat_i`, and consuming its `dat_o`.

## Interface
- `RAM_DEPTH`, 1024: RAM words. Local `AW = clogb2(RAM_DEPTH)` is the RAM address width.
- `DW`, 32: data width. Fixed at 4 byte lanes of 8 bits.
- `clk_i`  in  1: single clock. All state changes on the rising edge.
- `rst_n_i`  in  1: asynchronous, active-low reset.
- `wb_cyc_i`  in  1: bus cycle active.
- `wb_stb_i`  in  1: transfer strobe.
- `wb_we_i`  in  1: 1 = write, 0 = read.
- `wb_adr_i`  in  32: byte address.
- `wb_sel_i`  in  4: byte lane select.
- `wb_dat_i`  in  32: write data.
- `wb_dat_o`  out  32: read data, registered.
- `wb_ack_o`  out  1: transfer complete, one-cycle pulse.
- `wb_err_o`  out  1: bus error. Tied 0 unless `RAM_WB_ERR_EN` is defined.
- `ram_we_o`  out  1: RAM write enable.
- `ram_adr_o`  out  AW: RAM word address, `wb_adr_i[AW+1:2]`.
- `ram_be_o`  out  4: RAM byte enables, `wb_sel_i`.
- `ram_dat_o`  out  32: RAM write data, `wb_dat_i`.
- `ram_dat_i`  in  32: RAM read data, valid one cycle after the address is sampled.

## Operation
- FSM states: `IDLE`, `RD_WAIT`, `ACK`.
- **Request:** `req = wb_cyc_i & wb_stb_i`, taken only in `IDLE`.
- **`IDLE`, write** (`req & wb_we_i`):
  - `ram_we_o = 1` combinationally in this cycle.
  - The RAM commits the selected lanes at this edge.
  - Next state `ACK`.
- **`IDLE`, read** (`req & !wb_we_i`):
  - `ram_we_o = 0`; the RAM samples `ram_adr_o` at this edge.
  - Next state `RD_WAIT`.
- **`RD_WAIT`:**
  - `ram_dat_i` is valid; it is registered into `wb_dat_o` at the end of this cycle.
  - Next state `ACK`.
  - If `wb_cyc_i` drops in `RD_WAIT`, the transfer is aborted: next state `IDLE`, no ack, `wb_dat_o` unchanged.
- **`ACK`:** `wb_ack_o = 1` for exactly this cycle. Next state is always `IDLE`; a request is never accepted in `ACK`.
- **Write lanes:** `wb_sel_i = 0` on a write still acks, but no byte is modified.
- **RAM port in non-`IDLE` states:** `ram_we_o` is forced 0 outside `IDLE`. `ram_adr_o`, `ram_be_o` and `ram_dat_o` are pure pass-through at all times.
- **Address aliasing:** without the error feature, `wb_adr_i[1:0]` and `wb_adr_i[31:AW+2]` are ignored, so addresses alias modulo `4*RAM_DEPTH`.
- **Reset values:** state `IDLE`, `wb_ack_o = 0`, `wb_err_o = 0`, `wb_dat_o = 0`. `ram_we_o` is 0 while `rst_n_i` is low.
- **Reset mid-transfer:** returns to `IDLE` immediately with no ack. A write whose edge coincided with reset assertion is not guaranteed.

## Timing
- Write: request sampled at edge N; `wb_ack_o` high in cycle N+1. Two cycles per write.
- Read: request sampled at edge N; data registered at edge N+1; `wb_ack_o` and valid `wb_dat_o` in cycle N+2. Three cycles per read.
- `wb_dat_o` holds its value until the next completed read.
- Back-to-back transfers: the next request is accepted no earlier than the cycle after `ACK`.
- `wb_ack_o` and `wb_err_o` are never high together, and each is never high for two consecutive cycles.

## Configuration
- **`RAM_WB_ERR_EN` defined:**
  - In `IDLE`, a request with `wb_adr_i[31:AW+2] != 0` or `wb_adr_i[1:0] != 0` is an error.
  - On error, `ram_we_o` stays 0, the FSM goes to `ACK`, and `wb_err_o` pulses instead of `wb_ack_o`.
  - The RAM is untouched and `wb_dat_o` is unchanged.
- **Not defined:** `wb_err_o` is constant 0 and addresses alias as described in Operation.

## Test plan
- **Word write then read:** write 0xDEADBEEF to 0x10 with sel=0xF, then read 0x10 -> ack 1 cycle after the write strobe; read ack 2 cycles after its strobe with `wb_dat_o` = 0xDEADBEEF.
- **Byte-lane write:** after the above, write 0x00AA0000 with sel=0x4 to 0x10, then read -> 0xDEAABEEF.
- **Back-to-back reads:** reads of 0x0, 0x4 and 0x8 with stb held high -> one ack every 3 cycles, data matches preloaded values, no double ack.
- **Abort:** drop `wb_cyc_i` during `RD_WAIT` -> no ack, FSM returns to `IDLE`, `wb_dat_o` unchanged.
- **Reset during read:** assert `rst_n_i` low in `RD_WAIT` -> `wb_ack_o`, `wb_err_o` and `wb_dat_o` all 0 immediately; next transfer completes normally.
- **`RAM_WB_ERR_EN` defined:**
  - Write to 4*RAM_DEPTH -> `wb_err_o` pulses, no ack, location 0 unchanged.
  - Read at 0x2 -> `wb_err_o` pulses.
  - Without the macro, the same write aliases to word 0.
